// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the CORDIC iteration sequencer.
// Optional gain-compensation step is enabled by CORDIC_SCALE_STEP_EN.
package cordic_ctrl_pkg;

    localparam int ITER_DEF  = 16;
    localparam int CNT_W_DEF = 6;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_ITER  = 5'b00100,
        S_SCALE = 5'b01000,
        S_DONE  = 5'b10000
    } state_e;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Loadable saturating iteration counter; last flags index ITER-1.
module cordic_iter_cnt
    import cordic_ctrl_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == CNT_W'(ITER - 1));
    assign cnt  = cnt_q;

    // Saturate at ITER-1 so the index never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// CORDIC micro-rotation sequencer: load, ITER rotations, done/ack handshake.
// Define CORDIC_SCALE_STEP_EN to add a one-cycle gain-compensation step.
module cordic_iter_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ack,
    input  logic             z_sign,
    output logic             load_init,
    output logic             iter_en,
    output logic [CNT_W-1:0] iter_idx,
    output logic [CNT_W-1:0] lut_addr,
    output logic             op_x,
    output logic             op_y,
    output logic             op_z,
    output logic             scale_en,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt;

    cordic_iter_cnt #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_clr = 1'b1;
                state_d = S_ITER;
            end
            S_ITER: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
`ifdef CORDIC_SCALE_STEP_EN
                    state_d = S_SCALE;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_SCALE: state_d = S_DONE;
            S_DONE: begin
                // A start coinciding with ack is dropped on purpose.
                if (ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign load_init = (state_q == S_LOAD);
    assign iter_en   = (state_q == S_ITER);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign iter_idx  = cnt;
    assign lut_addr  = cnt;

`ifdef CORDIC_SCALE_STEP_EN
    assign scale_en = (state_q == S_SCALE);
`else
    assign scale_en = 1'b0;
`endif

    // Rotate toward zero residual angle: positive z subtracts on x and z.
    assign op_x = iter_en ? (z_sign ? OP_ADD : OP_SUB) : OP_ADD;
    assign op_y = iter_en ? (z_sign ? OP_SUB : OP_ADD) : OP_ADD;
    assign op_z = op_x;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboard bench for cordic_iter_ctrl against a cycle-offset reference model.
module tb_cordic_iter_ctrl;
    import cordic_ctrl_pkg::*;

    localparam int ITER  = ITER_DEF;
    localparam int CNT_W = CNT_W_DEF;
`ifdef CORDIC_SCALE_STEP_EN
    localparam int SCALE_CYC = 1;
`else
    localparam int SCALE_CYC = 0;
`endif
    localparam int DONE_T = ITER + 2 + SCALE_CYC;

    typedef logic [19:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic z_sign = 1'b0;

    logic             load_init;
    logic             iter_en;
    logic [CNT_W-1:0] iter_idx;
    logic [CNT_W-1:0] lut_addr;
    logic             op_x;
    logic             op_y;
    logic             op_z;
    logic             scale_en;
    logic             busy;
    logic             done;

    vec_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    // Model: t = cycles since start was accepted (0 = idle).
    int   t = 0;
    int   last_idx = 0;

    always #5 clk = ~clk;

    cordic_iter_ctrl #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ack       (ack),
        .z_sign    (z_sign),
        .load_init (load_init),
        .iter_en   (iter_en),
        .iter_idx  (iter_idx),
        .lut_addr  (lut_addr),
        .op_x      (op_x),
        .op_y      (op_y),
        .op_z      (op_z),
        .scale_en  (scale_en),
        .busy      (busy),
        .done      (done)
    );

    function automatic vec_t expect_vec(int tt, int li, logic z);
        logic             ld, it, sc, bz, dn, ox, oy;
        logic [CNT_W-1:0] ix;
        ld = (tt == 1);
        it = (tt >= 2) && (tt <= ITER + 1);
        sc = (SCALE_CYC == 1) && (tt == ITER + 2);
        bz = (tt != 0);
        dn = (tt == DONE_T);
        ix = it ? CNT_W'(tt - 2) : CNT_W'(li);
        ox = it && !z;
        oy = it && z;
        return {ld, it, ix, ix, ox, oy, ox, sc, bz, dn};
    endfunction

    task automatic cycle(input logic r, input logic s,
                         input logic a, input logic z);
        @(posedge clk);
        #2;
        rst_n  = r;
        start  = s;
        ack    = a;
        z_sign = z;
        exp_q.push_back(expect_vec(t, last_idx, z));
        if (t >= 2 && t <= ITER + 1) last_idx = t - 2;
        if (!r) begin
            t = 0;
            last_idx = 0;
        end else if (t == 0) begin
            t = s ? 1 : 0;
        end else if (t == DONE_T) begin
            t = a ? 0 : t;
        end else begin
            t = t + 1;
        end
    endtask

    task automatic run_to_done(input int zmode, input logic noise);
        int   g;
        logic z;
        g = 0;
        while (t != DONE_T && g < 200) begin
            case (zmode)
                0: z = 1'b0;
                1: z = g[0] ? 1'b0 : 1'b1;
                default: z = 1'($urandom);
            endcase
            cycle(1'b1, noise ? 1'($urandom) : 1'b0, 1'b0, z);
            g++;
        end
    endtask

    always @(negedge clk) begin
        vec_t e;
        vec_t act;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {load_init, iter_en, iter_idx, lut_addr,
                   op_x, op_y, op_z, scale_en, busy, done};
            n_chk++;
            if (act === e) begin
                n_pass++;
            end else begin
                $display("FAIL outputs cycle %0d: got %h want %h",
                         cyc, act, e);
            end
        end
    end

    initial begin
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'($urandom));

        // Nominal run with held DONE, then ack+start together.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_done(0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Alternating direction with stray start pulses.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_done(1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the cycle presenting iteration 7.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        while (t != 9) cycle(1'b1, 1'b0, 1'b0, 1'($urandom));
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_done(2, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Back-to-back: ack then start on the very next edge.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_done(2, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_done(2, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) != 0), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        @(posedge clk);
        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cordic_iter_ctrl.md
# cordic_iter_ctrl

Sequencer for the sine/cosine CORDIC datapath. It accepts a start request and loads the initial x/y/z registers. It then runs a fixed number of micro-rotation iterations, driving the shift amount, arctangent LUT address and per-lane add/subtract operation select from the residual-angle sign. It reports completion with a held done/ack handshake. It sits between the floating-point top-level FSM and the CORDIC add/sub, shifter and LUT datapath.

## Interface
- `ITER`, 16: number of micro-rotations, range 2..64.
- `CNT_W`, 6: width of the iteration index; must satisfy 2^CNT_W > ITER.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request a new computation; sampled only in IDLE.
- `ack`  in  1  consumer has taken the result; releases DONE.
- `z_sign`  in  1  sign bit of the current residual angle z (1 = negative).
- `load_init`  out  1  load initial x/y/z into the datapath registers.
- `iter_en`  out  1  enable datapath register update for this iteration.
- `iter_idx`  out  CNT_W  current iteration i; also serves as shift amount.
- `lut_addr`  out  CNT_W  arctangent LUT address (equals iter_idx).
- `op_x`  out  1  x lane operation: 1 = subtract, 0 = add.
- `op_y`  out  1  y lane operation.
- `op_z`  out  1  z lane operation.
- `scale_en`  out  1  gain-compensation step enable (only with the macro below).
- `busy`  out  1  high outside IDLE.
- `done`  out  1  result valid; held until ack.

## Operation
- States: IDLE, LOAD, ITER, SCALE (only when the macro below is defined), DONE. Encoding is one-hot.
- IDLE: when `start`=1, go to LOAD. Otherwise stay.
- LOAD: one cycle with `load_init`=1. Clear the counter to 0. Go to ITER.
- ITER: `iter_en`=1 every cycle, and `iter_idx`=`lut_addr`=counter.
  - Direction d = ~`z_sign`.
  - `op_x` = d, giving x − y·2^-i when z ≥ 0.
  - `op_y` = `z_sign`, giving y + x·2^-i when z ≥ 0.
  - `op_z` = d, giving z − atan(2^-i) when z ≥ 0.
  - These are pure XOR selects against registered state. They are combinational from `z_sign`, with no added latency.
  - The counter increments each cycle. When counter = ITER−1, go to SCALE if the macro is defined, else DONE. The counter saturates at ITER−1 and never wraps.
- SCALE: one cycle with `scale_en`=1. Go to DONE.
- DONE: `done`=1. When `ack`=1, go to IDLE, with `done` low from the next cycle.
  - If `ack` and `start` are both high in DONE, go to IDLE. The new `start` is not captured and must be re-asserted.
- `start` is ignored whenever `busy`=1.
- Outside ITER: `iter_en`=0, `op_*`=0, and `iter_idx`/`lut_addr` hold the counter value.

## Timing
- Reset values: state IDLE, counter 0. All outputs are 0: `load_init`, `iter_en`, `iter_idx`, `lut_addr`, `op_*`, `scale_en`, `busy`, `done`.
- `start` high at edge k puts the block in LOAD during cycle k+1. Cycles k+2 .. k+1+ITER are ITER. `done` rises at cycle k+2+ITER, or k+3+ITER with SCALE.
- Start-to-done latency: ITER+2 cycles, or ITER+3 with SCALE.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `ack` is accepted.
- `rst_n`=0 at any edge, including mid-ITER or DONE, forces IDLE and all outputs to 0 on that edge. A partially computed result is discarded.
- `z_sign` must be stable before the rising edge in each ITER cycle. The datapath presents the z of the current iteration.
- Back-to-back operation: `ack` at DONE edge m, then `start` at edge m+1 gives LOAD at m+2.

## Configuration
- `CORDIC_SCALE_STEP_EN` defined: the SCALE state exists, `scale_en` pulses for one cycle after the last iteration, and latency is ITER+3.
- Not defined: no SCALE state, `scale_en` is tied to 0, ITER goes straight to DONE, and latency is ITER+2.

## Structure
- Shared package `cordic_ctrl_pkg` holds:
  - the state one-hot encodings;
  - the `OP_ADD`=0 and `OP_SUB`=1 constants;
  - the default ITER and CNT_W.
- One sub-module, `cordic_iter_cnt`: a loadable, saturating up-counter with `clr`, `en` and `last` (counter = ITER−1) outputs.
- The FSM and direction-select logic stay in `cordic_iter_ctrl`.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, then release with `start`=0 for 10 cycles → all outputs stay 0 and state stays IDLE.
- Nominal run, ITER=16, no macro: pulse `start`, tie `z_sign`=0 → `load_init` for 1 cycle, then 16 cycles of `iter_en` with `iter_idx` 0..15 and `op_x`=`op_z`=1, `op_y`=0. `done` rises 18 cycles after `start`.
- Direction tracking: drive `z_sign` alternating 1,0,1,… during ITER → in each cycle `op_x`=`op_z`=~`z_sign` and `op_y`=`z_sign`, with zero-cycle delay.
- Handshake: hold `ack`=0 for 5 cycles in DONE, then pulse `ack`=1 → `done` held high for those 5 cycles, then IDLE. A `start` asserted in the DONE cycle together with `ack` is not captured (no LOAD follows). A `start` pulsed during ITER has no effect.
- Reset mid-run: drive `rst_n`=0 at iteration 7 → next cycle is IDLE with all outputs 0. A new `start` then gives a full run of 16 iterations starting from index 0.
- With `CORDIC_SCALE_STEP_EN`: nominal run → `scale_en` high for exactly 1 cycle right after `iter_idx`=15, and `done` rises at start+19.
